// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared constants and state encoding for the 7-segment scanner
package seg7_scan_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order {a,b,c,d,e,f,g}, a in the MSB.
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - BCD inputs and display outputs of the scanner
interface seg7_scan_if;
    import seg7_scan_pkg::*;

    logic [3:0]            BCD0;
    logic [3:0]            BCD1;
    logic [3:0]            BCD2;
    logic [3:0]            BCD3;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_tick;

    modport master (
        output BCD0, BCD1, BCD2, BCD3, blank_lz,
        input  seg, an, frame_tick
    );

    modport slave (
        input  BCD0, BCD1, BCD2, BCD3, blank_lz,
        output seg, an, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to segment code, dark for values above 9
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - time-multiplexed 4-digit display driver with per-frame snapshot
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES   = 4,
    parameter int unsigned BLANK_CYCLES   = 1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       Clock,
    input  logic       Clear,
    seg7_scan_if.slave bus
);

    localparam logic [15:0] DIG_LAST = 16'(DIGIT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = (BLANK_CYCLES > 0) ? 16'(BLANK_CYCLES - 1) : 16'd0;

    state_t                state, nxt_state;
    logic [1:0]            idx, nxt_idx;
    logic [15:0]           cnt, nxt_cnt;
    logic [15:0]           snap, nxt_snap;
    logic                  blank_q, nxt_blank;
    logic                  first;
    logic                  advance, frame_start, blanked;
    logic [3:0]            lz;
    logic [3:0]            dig;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  tick_q;

    // Next state is computed here so the output registers can present it on the same edge.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 16'd1;
        advance   = 1'b0;
        if (first) begin
            nxt_cnt = 16'd0;
        end else begin
            case (state)
                ST_SHOW: begin
                    if (cnt == DIG_LAST) begin
                        nxt_cnt = 16'd0;
                        if (BLANK_CYCLES > 0) begin
                            nxt_state = ST_GAP;
                        end else begin
                            nxt_idx = idx + 2'd1;
                            advance = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        nxt_cnt   = 16'd0;
                        nxt_idx   = idx + 2'd1;
                        nxt_state = ST_SHOW;
                        advance   = 1'b1;
                    end
                end
                default: nxt_state = ST_SHOW;
            endcase
        end
        frame_start = first || (advance && (nxt_idx == 2'd0));
        nxt_snap    = frame_start ? {bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0} : snap;
        nxt_blank   = frame_start ? bus.blank_lz : blank_q;
        dig         = nxt_snap[{nxt_idx, 2'b00} +: 4];
        // lz[k]: snapshot digits k..3 are all zero
        lz[3]       = (nxt_snap[15:12] == 4'd0);
        lz[2]       = lz[3] && (nxt_snap[11:8] == 4'd0);
        lz[1]       = lz[2] && (nxt_snap[7:4] == 4'd0);
        lz[0]       = lz[1] && (nxt_snap[3:0] == 4'd0);
        blanked     = nxt_blank && (nxt_idx != 2'd0) && lz[nxt_idx];
    end

    seg7_decode u_decode (
        .digit (dig),
        .seg   (dec_seg)
    );

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state   <= ST_SHOW;
            idx     <= 2'd0;
            cnt     <= 16'd0;
            snap    <= 16'd0;
            blank_q <= 1'b0;
            first   <= 1'b1;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state   <= nxt_state;
            idx     <= nxt_idx;
            cnt     <= nxt_cnt;
            snap    <= nxt_snap;
            blank_q <= nxt_blank;
            first   <= 1'b0;
            tick_q  <= frame_start;
            if (nxt_state == ST_SHOW) begin
                an_q  <= 4'b0001 << nxt_idx;
                seg_q <= blanked ? SEG_BLANK : dec_seg;
            end else begin
                an_q  <= '0;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign bus.seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
    assign bus.an         = an_q ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized scoreboard bench for seg7_scan, two parameter sets
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] bcd [4];
    logic       blz;

    seg7_scan_if bus_a ();
    seg7_scan_if bus_b ();

    assign bus_a.BCD0 = bcd[0];
    assign bus_a.BCD1 = bcd[1];
    assign bus_a.BCD2 = bcd[2];
    assign bus_a.BCD3 = bcd[3];
    assign bus_a.blank_lz = blz;
    assign bus_b.BCD0 = bcd[0];
    assign bus_b.BCD1 = bcd[1];
    assign bus_b.BCD2 = bcd[2];
    assign bus_b.BCD3 = bcd[3];
    assign bus_b.blank_lz = blz;

    seg7_scan #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .Clock (clk),
        .Clear (clr),
        .bus   (bus_a.slave)
    );

    seg7_scan #(.DIGIT_CYCLES(2), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .Clock (clk),
        .Clear (clr),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [11:0] q0 [$];
    logic [11:0] q1 [$];

    int          dc   [2] = '{4, 2};
    int          bc   [2] = '{1, 0};
    bit          inv  [2] = '{1'b0, 1'b1};
    int          t_m  [2] = '{0, 0};
    logic [3:0]  snap_m [2][4];
    logic        blk_m  [2];
    logic [6:0]  tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    logic [16:0] dir_tab [6] = '{17'h0_1234, 17'h1_0007, 17'h0_0007,
                                 17'h1_0500, 17'h0_000C, 17'h1_0000};

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got tick=%b an=%b seg=%b expected tick=%b an=%b seg=%b",
                     name, cyc, got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
        end
    endtask

    // Display position is derived from the time since reset release and the frame geometry.
    task automatic model(input int i, output logic [11:0] e);
        int p, per, d, w;
        logic [6:0] s;
        logic [3:0] a;
        logic tk, z;
        s = 7'd0; a = 4'd0; tk = 1'b0;
        if (clr) begin
            t_m[i] = 0;
        end else begin
            t_m[i]++;
            per = dc[i] + bc[i];
            p = (t_m[i] - 1) % (4 * per);
            if (p == 0) begin
                for (int k = 0; k < 4; k++) snap_m[i][k] = bcd[k];
                blk_m[i] = blz;
                tk = 1'b1;
            end
            d = p / per;
            w = p % per;
            if (w < dc[i]) begin
                a = 4'(1 << d);
                z = blk_m[i] && (d > 0);
                for (int k = d; k < 4; k++) if (snap_m[i][k] != 4'd0) z = 1'b0;
                s = z ? 7'd0 : tab[snap_m[i][d]];
            end
        end
        if (inv[i]) begin
            s = ~s;
            a = ~a;
        end
        e = {tk, a, s};
    endtask

    task automatic step(input logic c, input logic [16:0] v);
        logic prev;
        logic [11:0] e;
        @(negedge clk);
        cyc++;
        prev = clr;
        clr = c;
        {blz, bcd[3], bcd[2], bcd[1], bcd[0]} = v;
        if (c && !prev) begin
            #1;
            check("async_clear_a", {bus_a.frame_tick, bus_a.an, bus_a.seg}, 12'h000);
            check("async_clear_b", {bus_b.frame_tick, bus_b.an, bus_b.seg}, {1'b0, 4'hF, 7'h7F});
        end
        model(0, e);
        q0.push_back(e);
        model(1, e);
        q1.push_back(e);
    endtask

    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("scan_a", {bus_a.frame_tick, bus_a.an, bus_a.seg}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("scan_b", {bus_b.frame_tick, bus_b.an, bus_b.seg}, e);
            end
        end
    end

    initial begin
        logic [16:0] v;
        logic        c;
        for (int k = 0; k < 4; k++) bcd[k] = 4'd0;
        blz = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b1, 17'h0);
        for (int t = 0; t < 6; t++) begin
            for (int n = 0; n < 45; n++) step((t == 4) && (n == 7), dir_tab[t]);
        end
        // Mid-frame digit-0 change: 3 shown for the rest of the frame, 4 after the next tick.
        for (int n = 0; n < 30; n++) step(1'b0, (n < 10) ? 17'h0_0003 : 17'h0_0004);
        v = 17'h0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                v[16] = 1'($urandom_range(0, 1));
                for (int k = 0; k < 4; k++)
                    v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            c = ($urandom_range(0, 149) == 0);
            step(c, v);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got q0=%0d q1=%0d expected 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Time-multiplexed driver for a 4-digit common-segment 7-segment display. It sits directly downstream of the 4-digit BCD stopwatch counter and consumes its BCD3..BCD0 outputs. It drives one shared 7-bit segment bus and four digit enables in turn. It snapshots all four digits once per frame to prevent tearing, blanks leading zeros on request, and inserts a dark gap between digits to suppress ghosting.

Parameters:
DIGIT_CYCLES, 4, number of clocks each digit is lit (legal range 1..65535).
BLANK_CYCLES, 1, number of dark clocks after each digit (0 means no gap state).
SEG_ACTIVE_LOW, 0, when 1, seg and an are inverted at the output pins.

Ports:
Clock  in  1  system clock, rising edge.
Clear  in  1  reset, asynchronous, active-high.
BCD0  in  4  least significant digit from the BCD counter.
BCD1  in  4  digit 1.
BCD2  in  4  digit 2.
BCD3  in  4  most significant digit.
blank_lz  in  1  1 = blank leading zeros on digits 3..1.
seg  out  7  segments {a,b,c,d,e,f,g}, a = MSB; 0→7'b1111110, 8→7'b1111111.
an  out  4  digit enables, one-hot, an[k] lights digit k.
frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (Clear=1, asynchronous): state=SHOW, idx=0, cnt=0, snapshot=0, first=1. Outputs seg=0, an=0, frame_tick=0 before SEG_ACTIVE_LOW inversion. Reset mid-frame aborts the scan immediately; no partial-digit completion.
- States: SHOW and GAP. The 2-bit digit index idx scans 0→1→2→3→0. A 16-bit cycle counter cnt runs within each state.
- SHOW: cnt counts 0..DIGIT_CYCLES-1. On the last count, cnt goes to 0 and the FSM moves to GAP if BLANK_CYCLES>0. Otherwise idx increments and the FSM stays in SHOW.
- GAP: cnt counts 0..BLANK_CYCLES-1. On the last count, cnt goes to 0, idx increments (mod 4), and the FSM moves to SHOW.
- Frame start is any transition into SHOW with idx=0, including the first clock after Clear deasserts (first=1, which then clears). On that edge:
  - snapshot ← {BCD3, BCD2, BCD1, BCD0};
  - frame_tick=1 for exactly that one cycle.
- Input changes mid-frame are not displayed until the next frame start.
- Outputs are registered and reflect the current state with zero added latency:
  - SHOW: an = one-hot(idx) for exactly DIGIT_CYCLES consecutive cycles; seg = decode(snapshot[idx]) unless that digit is blanked.
  - GAP: an = 0, seg = 0.
- Leading-zero blanking: digit k (k=3,2,1) is blanked when blank_lz=1 and snapshot digits k..3 are all 0. Digit 0 is never blanked.
  - A blanked digit still occupies its slot with an = one-hot(idx) and seg = 0, so frame period stays constant.
  - blank_lz is sampled with the snapshot.
- Decode: 0..9 use the standard codes (1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 9=1111011). Values 10..15 give seg=0.
- Frame period = 4×(DIGIT_CYCLES+BLANK_CYCLES) clocks. Default = 20.
- an never has more than one bit set. an is never nonzero in GAP.

Decomposition:
- Shared package: 7-bit segment code constants for 0..9 and blank; state encoding (SHOW, GAP); digit count constant 4.
- One sub-module, seg7_decode: a pure combinational 4-bit to 7-bit decoder with blank for values above 9. Instantiate once on the snapshot[idx] mux output.

Test Plan:
- Reset then BCD={1,2,3,4}, blank_lz=0, defaults → frame_tick at cycle 1. an=0001 seg=0110011 for 4 cycles, 1 dark cycle, then 0010/1111001, 0100/1101101, 1000/0110000. frame_tick repeats every 20 cycles.
- BCD={0,0,0,7}, blank_lz=1 → digit 0 shows 1110000; digits 1..3 have an one-hot with seg=0. With blank_lz=0, digits 1..3 show 1111110.
- BCD={0,5,0,0}, blank_lz=1 → digit 3 blanked; digits 2,1,0 show 1011011, 1111110, 1111110 (embedded zeros not blanked).
- Change BCD0 from 3 to 4 while idx=2 → digit 0 shows 1111001 (3) for the rest of the frame and 0110011 (4) after the next frame_tick.
- BCD0=4'hC → seg=0 for digit 0 with an=0001. Assert Clear at cycle 7 for 1 cycle → seg=0, an=0 immediately; scan restarts at idx=0 with frame_tick on the first clock after release.
- BLANK_CYCLES=0, DIGIT_CYCLES=2 → no dark cycles; frame period 8; an steps 0001→0010→0100→1000 every 2 cycles.
